regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (RegWr/RW/BusW, captured on falling Clk edge) between two writeback sources: memory-load return (Mem) and ALU result (ALU).
- Each source uses a valid/ready handshake.
- Arbitration is Mem-priority, with a starvation guard that forces an ALU grant after MAX_WAIT consecutive losses.
- Outputs are registered on the rising edge, so the register file samples stable values at the following falling edge.

---
 rtl/regfile_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between Mem (priority) and ALU writeback sources,
// with a starvation guard. Optional statistics counters are enabled by REGARB_STATS_EN.
module regfile_wr_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Hold,
    input  logic              MemValid,
    output logic              MemReady,
    input  logic [4:0]        MemRW,
    input  logic [63:0]       MemBusW,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [4:0]        AluRW,
    input  logic [63:0]       AluBusW,
`ifdef REGARB_STATS_EN
    output logic [CNT_W-1:0]  MemGrants,
    output logic [CNT_W-1:0]  AluGrants,
    output logic [CNT_W-1:0]  Conflicts,
`endif
    output logic              RegWr,
    output logic [4:0]        RW,
    output logic [63:0]       BusW
);

    typedef enum logic [0:0] {StPriMem, StForceAlu} state_e;

    state_e      stateQ, stateD;
    logic [3:0]  waitCntQ, waitCntD;
    logic        regWrD;
    logic [4:0]  rwD;
    logic [63:0] busWD;
    logic        memAcc, aluAcc, aluLoss;

    always_comb begin
        MemReady = 1'b0;
        AluReady = 1'b0;
        unique case (stateQ)
            StPriMem: begin
                MemReady = !Hold;
                AluReady = !Hold && !MemValid;
            end
            StForceAlu: begin
                AluReady = !Hold;
                MemReady = !Hold && !AluValid;
            end
            default: ;
        endcase
    end

    assign memAcc  = MemValid && MemReady;
    assign aluAcc  = AluValid && AluReady;
    assign aluLoss = !Hold && AluValid && !AluReady;

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCntQ;
        if (aluAcc) begin
            waitCntD = 4'd0;
            stateD   = StPriMem;
        end else if (aluLoss) begin
            if (waitCntQ == 4'(MAX_WAIT - 1)) begin
                stateD   = StForceAlu;
                waitCntD = 4'd0;
            end else begin
                waitCntD = waitCntQ + 4'd1;
            end
        end
    end

    // X31 requests complete the handshake but never reach the register file.
    always_comb begin
        regWrD = 1'b0;
        rwD    = RW;
        busWD  = BusW;
        if (memAcc && MemRW != 5'd31) begin
            regWrD = 1'b1;
            rwD    = MemRW;
            busWD  = MemBusW;
        end else if (aluAcc && AluRW != 5'd31) begin
            regWrD = 1'b1;
            rwD    = AluRW;
            busWD  = AluBusW;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ   <= StPriMem;
            waitCntQ <= 4'd0;
            RegWr    <= 1'b0;
            RW       <= 5'd0;
            BusW     <= 64'd0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
            RegWr    <= regWrD;
            RW       <= rwD;
            BusW     <= busWD;
        end
    end

`ifdef REGARB_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MemGrants <= '0;
            AluGrants <= '0;
            Conflicts <= '0;
        end else begin
            if (memAcc && MemGrants != '1) MemGrants <= MemGrants + CNT_W'(1);
            if (aluAcc && AluGrants != '1) AluGrants <= AluGrants + CNT_W'(1);
            if (MemValid && AluValid && !Hold && Conflicts != '1) begin
                Conflicts <= Conflicts + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (MAX_WAIT=3).
module tb_regfile_wr_arbiter;

    logic        Clk, Reset, Hold;
    logic        MemValid, MemReady, AluValid, AluReady;
    logic [4:0]  MemRW, AluRW, RW;
    logic [63:0] MemBusW, AluBusW, BusW;
    logic        RegWr;
`ifdef REGARB_STATS_EN
    logic [15:0] MemGrants, AluGrants, Conflicts;
`endif

    int nChecks = 0;
    int nFails  = 0;
    logic [63:0] memData, lastBus;

    regfile_wr_arbiter #(.MAX_WAIT(3), .CNT_W(16)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Hold     (Hold),
        .MemValid (MemValid),
        .MemReady (MemReady),
        .MemRW    (MemRW),
        .MemBusW  (MemBusW),
        .AluValid (AluValid),
        .AluReady (AluReady),
        .AluRW    (AluRW),
        .AluBusW  (AluBusW),
`ifdef REGARB_STATS_EN
        .MemGrants(MemGrants),
        .AluGrants(AluGrants),
        .Conflicts(Conflicts),
`endif
        .RegWr    (RegWr),
        .RW       (RW),
        .BusW     (BusW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Hold = 1'b0;
        MemValid = 1'b0; MemRW = 5'd0; MemBusW = 64'd0;
        AluValid = 1'b0; AluRW = 5'd0; AluBusW = 64'd0;
        #2;
        checkVal("rst_regwr", RegWr, 0);
        checkVal("rst_rw", RW, 0);
        checkVal("rst_busw", BusW, 0);
        @(negedge Clk);
        Reset = 1'b0;
        tick();

        // Single ALU request
        AluValid = 1'b1; AluRW = 5'd5; AluBusW = 64'hDEAD;
        #1;
        checkVal("single_aluready", AluReady, 1);
        tick();
        AluValid = 1'b0;
        checkVal("single_regwr", RegWr, 1);
        checkVal("single_rw", RW, 5);
        checkVal("single_busw", BusW, 64'hDEAD);
        tick();
        checkVal("single_regwr_off", RegWr, 0);
        checkVal("single_rw_hold", RW, 5);

        // Mem priority
        MemValid = 1'b1; MemRW = 5'd2; MemBusW = 64'h22;
        AluValid = 1'b1; AluRW = 5'd3; AluBusW = 64'h33;
        #1;
        checkVal("pri_memready", MemReady, 1);
        checkVal("pri_aluready", AluReady, 0);
        tick();
        MemValid = 1'b0;
        checkVal("pri_rw_mem", RW, 2);
        checkVal("pri_busw_mem", BusW, 64'h22);
        #1;
        checkVal("pri_aluready2", AluReady, 1);
        tick();
        AluValid = 1'b0;
        checkVal("pri_regwr_alu", RegWr, 1);
        checkVal("pri_rw_alu", RW, 3);
        checkVal("pri_busw_alu", BusW, 64'h33);

        // Starvation guard: ALU wins on the 4th cycle, Mem pauses once
        memData = 64'h100;
        MemValid = 1'b1; MemRW = 5'd7; MemBusW = memData;
        AluValid = 1'b1; AluRW = 5'd9; AluBusW = 64'hA1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checkVal($sformatf("starve_memready_%0d", c), MemReady, (c != 3));
            checkVal($sformatf("starve_aluready_%0d", c), AluReady, (c == 3));
            tick();
            checkVal($sformatf("starve_regwr_%0d", c), RegWr, 1);
            if (c == 3) begin
                checkVal("starve_rw_alu", RW, 9);
                checkVal("starve_busw_alu", BusW, 64'hA1);
                AluValid = 1'b0;
            end else begin
                checkVal($sformatf("starve_busw_%0d", c), BusW, memData);
                lastBus = memData;
                memData = memData + 64'd1;
                MemBusW = memData;
            end
        end
        MemValid = 1'b0;

        // X31 is accepted but dropped
        MemValid = 1'b1; MemRW = 5'd31; MemBusW = 64'h1234;
        #1;
        checkVal("x31_memready", MemReady, 1);
        tick();
        MemValid = 1'b0;
        checkVal("x31_regwr", RegWr, 0);
        checkVal("x31_rw", RW, 7);
        checkVal("x31_busw", BusW, lastBus);

        // Two losses, then Hold must freeze the wait count
        MemValid = 1'b1; MemRW = 5'd4; MemBusW = 64'h44;
        AluValid = 1'b1; AluRW = 5'd6; AluBusW = 64'h66;
        tick();
        tick();
        Hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkVal($sformatf("hold_memready_%0d", c), MemReady, 0);
            checkVal($sformatf("hold_aluready_%0d", c), AluReady, 0);
            tick();
            checkVal($sformatf("hold_regwr_%0d", c), RegWr, 0);
        end
        Hold = 1'b0;
        #1;
        checkVal("unhold_memready", MemReady, 1);
        checkVal("unhold_aluready", AluReady, 0);
        tick();
        checkVal("unhold_regwr", RegWr, 1);
        checkVal("unhold_rw", RW, 4);
        checkVal("force_aluready", AluReady, 1);
        checkVal("force_memready", MemReady, 0);

        // Asynchronous reset mid-writeback
        #1;
        Reset = 1'b1;
        #1;
        checkVal("arst_regwr", RegWr, 0);
        checkVal("arst_rw", RW, 0);
        checkVal("arst_busw", BusW, 0);
        checkVal("arst_memready", MemReady, 1);
        checkVal("arst_aluready", AluReady, 0);
        MemValid = 1'b0; AluValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        tick();

`ifdef REGARB_STATS_EN
        Reset = 1'b1;
        #1;
        checkVal("stats_rst_mem", MemGrants, 0);
        Reset = 1'b0;
        tick();
        MemValid = 1'b1; MemRW = 5'd1; AluRW = 5'd2;
        tick(); tick(); tick();
        MemValid = 1'b0; AluValid = 1'b1;
        tick(); tick();
        MemValid = 1'b1;
        tick(); tick();
        MemValid = 1'b0; AluValid = 1'b0;
        #1;
        checkVal("stats_memgrants", MemGrants, 5);
        checkVal("stats_alugrants", AluGrants, 2);
        checkVal("stats_conflicts", Conflicts, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
